// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch into a DEPTH-entry FIFO with branch/PC-write redirect.
// Optional feature macro: FETCH_PC_WRITE_EN (PC writes from the memory stage redirect fetch).
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_pc_i,
    input  logic [23:0]     br_off_i,
    input  logic            pc_wr_i,
    input  logic [XLEN-1:0] pc_wr_data_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [XLEN-1:0] PC_STEP        = XLEN'(32'd4);
    localparam logic [XLEN-1:0] PC_BRANCH_BIAS = XLEN'(32'd8);
    localparam logic [PW-1:0]   PTR_ONE        = PW'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE        = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_DEPTH      = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [XLEN-1:0]   fetch_pc_r;
    logic              inflight_r;
    logic [XLEN-1:0]   inflight_pc_r;
    logic [XLEN-1:0]   mem_inst_r [DEPTH];
    logic [XLEN-1:0]   mem_pc_r   [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;

    logic              redirect_s;
    logic [XLEN-1:0]   target_s;
    logic [CW-1:0]     occupancy_s;
    logic              space_s;
    logic              imem_req_s;
    logic              push_s;
    logic              pop_s;

    // Branch target: PC + 8 plus the sign-extended word offset, wrapping in XLEN bits.
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                      input logic [23:0]     off);
        logic [XLEN-1:0] off_ext;
        off_ext = {{(XLEN-24){off[23]}}, off};
        return pc + PC_BRANCH_BIAS + (off_ext << 2);
    endfunction

    // Redirect source selection; a PC write outranks a taken branch.
    always_comb begin
        redirect_s = br_taken_i;
        target_s   = branch_target(br_pc_i, br_off_i);
`ifdef FETCH_PC_WRITE_EN
        if (pc_wr_i) begin
            redirect_s = 1'b1;
            target_s   = {pc_wr_data_i[XLEN-1:2], 2'b00};
        end else begin
            redirect_s = br_taken_i;
        end
`endif
    end

`ifndef FETCH_PC_WRITE_EN
    logic unused_pc_wr_s;
    assign unused_pc_wr_s = ^{pc_wr_i, pc_wr_data_i};
`endif

    // Queued entries plus the outstanding response must stay within DEPTH.
    always_comb begin
        occupancy_s = count_r + {{(CW-1){1'b0}}, inflight_r};
        space_s     = (occupancy_s < CNT_DEPTH);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and fetch request decode.
    always_comb begin
        state_nxt_s = state_r;
        imem_req_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_s) begin
                    state_nxt_s = ST_REDIR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN, ST_REDIR: begin
                if (redirect_s) begin
                    state_nxt_s = ST_REDIR;
                end else begin
                    state_nxt_s = ST_RUN;
                    imem_req_s  = space_s & ~rst;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pop_s  = (count_r != '0) & inst_ready_i;
        push_s = inflight_r & ~redirect_s;
    end

    // Fetch PC and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else begin
            if (redirect_s) begin
                fetch_pc_r <= target_s;
            end else if (imem_req_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            inflight_r <= imem_req_s;
            if (imem_req_s) begin
                inflight_pc_r <= fetch_pc_r;
            end else begin
                inflight_pc_r <= inflight_pc_r;
            end
        end
    end

    // FIFO storage, pointers and count; a redirect discards everything, including a same-cycle pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_inst_r <= '{default: '0};
            mem_pc_r   <= '{default: '0};
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
        end else if (redirect_s) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_inst_r[wr_ptr_r] <= imem_data_i;
                mem_pc_r[wr_ptr_r]   <= inflight_pc_r;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign imem_req_o   = imem_req_s;
    assign imem_addr_o  = fetch_pc_r;
    assign inst_valid_o = (count_r != '0);
    assign inst_o       = mem_inst_r[rd_ptr_r];
    assign inst_pc_o    = mem_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = 32'h0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_pc_i = 32'h0;
    logic [23:0] br_off_i = 24'h0;
    logic        pc_wr_i = 1'b0;
    logic [31:0] pc_wr_data_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b1;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .br_taken_i(br_taken_i), .br_pc_i(br_pc_i), .br_off_i(br_off_i),
        .pc_wr_i(pc_wr_i), .pc_wr_data_i(pc_wr_data_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_ready_i(inst_ready_i)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: queued PCs, next fetch address, one outstanding request.
    logic [31:0] m_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_idle = 1'b1;
    bit          m_inflight = 1'b0;
    logic [31:0] m_inflight_pc = 32'h0;
    bit          m_zero_head = 1'b1;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_inst, s_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [23:0] off);
        int woff;
        woff = int'($signed(off));
        return pc + 32'd8 + 32'(woff * 4);
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit          redir, exp_req, exp_valid, pop;
        logic [31:0] tgt;
        @(negedge clk);
        s_req = imem_req_o; s_addr = imem_addr_o; s_valid = inst_valid_o;
        s_inst = inst_o; s_pc = inst_pc_o;
        redir = br_taken_i;
        tgt   = br_target(br_pc_i, br_off_i);
`ifdef FETCH_PC_WRITE_EN
        if (pc_wr_i) begin
            redir = 1'b1;
            tgt   = pc_wr_data_i & 32'hFFFF_FFFC;
        end
`endif
        exp_req   = !rst && !m_idle && !redir && ((m_q.size() + int'(m_inflight)) < DEPTH);
        exp_valid = (m_q.size() != 0);
        check_eq("req", {31'd0, s_req}, {31'd0, exp_req});
        if (exp_req && s_req) check_eq("addr", s_addr, m_pc);
        check_eq("valid", {31'd0, s_valid}, {31'd0, exp_valid});
        if (exp_valid && s_valid) begin
            check_eq("head_pc", s_pc, m_q[0]);
            check_eq("head_inst", s_inst, mem_fn(m_q[0]));
        end else if (m_zero_head) begin
            check_eq("zero_pc", s_pc, 32'h0);
            check_eq("zero_inst", s_inst, 32'h0);
        end
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_pc = RESET_PC; m_idle = 1'b1; m_inflight = 1'b0; m_zero_head = 1'b1;
        end else begin
            pop = exp_valid && inst_ready_i;
            if (redir) begin
                m_q.delete();
                m_inflight = 1'b0;
                m_pc = tgt;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_inflight) begin
                    m_q.push_back(m_inflight_pc);
                    m_zero_head = 1'b0;
                end
                m_inflight = exp_req;
                if (exp_req) begin
                    m_inflight_pc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
            end
            m_idle = 1'b0;
        end
        #1;
        imem_data_i = s_req ? mem_fn(s_addr) : $urandom;
    endtask

    task automatic branch(input logic [31:0] pc, input logic [23:0] off);
        br_taken_i = 1'b1; br_pc_i = pc; br_off_i = off;
        cycle();
        br_taken_i = 1'b0;
    endtask

    logic [31:0] exp_resume;

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        cycle();
        check_eq("rst_req", {31'd0, s_req}, 32'd0);
        check_eq("rst_valid", {31'd0, s_valid}, 32'd0);
        check_eq("rst_inst", s_inst, 32'h0);
        check_eq("rst_pc", s_pc, 32'h0);
        rst = 1'b0;

        // Sequential fetch after reset
        cycle(); check_eq("idle_req", {31'd0, s_req}, 32'd0);
        cycle(); check_eq("req0", {31'd0, s_req}, 32'd1); check_eq("addr0", s_addr, 32'h0);
        cycle(); check_eq("addr1", s_addr, 32'h4);
        cycle(); check_eq("addr2", s_addr, 32'h8); check_eq("head0", s_pc, 32'h0);
        cycle(); check_eq("head1", s_pc, 32'h4);
        cycle(); check_eq("head2", s_pc, 32'h8);

        // Branch with negative offset back onto itself
        branch(32'h100, 24'hFFFFFE);
        cycle();
        check_eq("br_flush_valid", {31'd0, s_valid}, 32'd0);
        check_eq("br_target", s_addr, 32'h100);
        cycle();
        cycle(); check_eq("br_head", s_pc, 32'h100);

        // PC write and branch together
`ifdef FETCH_PC_WRITE_EN
        exp_resume = 32'h2000;
`else
        exp_resume = 32'h148;
`endif
        pc_wr_i = 1'b1; pc_wr_data_i = 32'h2003;
        branch(32'h100, 24'h000010);
        pc_wr_i = 1'b0;
        cycle(); check_eq("pcwr_resume", s_addr, exp_resume);
        cycle();
        cycle(); check_eq("pcwr_head", s_pc, exp_resume);

        // Address wrap at the top of the space
        branch(32'hFFFF_FFF4, 24'h000000);
        cycle(); check_eq("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
        cycle(); check_eq("wrap_addr_zero", s_addr, 32'h0);
        cycle(); check_eq("wrap_head_top", s_pc, 32'hFFFF_FFFC);
        cycle(); check_eq("wrap_head_zero", s_pc, 32'h0);

        // Full queue with stalled decoder
        rst = 1'b1; inst_ready_i = 1'b0;
        cycle();
        rst = 1'b0;
        repeat (12) cycle();
        check_eq("full_req", {31'd0, s_req}, 32'd0);
        check_eq("full_valid", {31'd0, s_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("stall_pc", s_pc, 32'h0);
            check_eq("stall_inst", s_inst, mem_fn(32'h0));
        end
        inst_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("drain_pc", s_pc, 32'(i * 4));
        end

        // Reset with three queued entries and one response in flight
        rst = 1'b1; inst_ready_i = 1'b0;
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        check_eq("pre_rst_addr", s_addr, 32'hC);
        rst = 1'b1;
        cycle(); check_eq("pre_rst_valid", {31'd0, s_valid}, 32'd1);
        rst = 1'b0;
        cycle(); check_eq("post_rst_empty", {31'd0, s_valid}, 32'd0);
        inst_ready_i = 1'b1;
        for (int i = 0; i < 20 && !s_valid; i++) cycle();
        check_eq("post_rst_seen", {31'd0, s_valid}, 32'd1);
        check_eq("post_rst_head", s_pc, RESET_PC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            inst_ready_i = ($urandom_range(3) != 0);
            br_taken_i   = ($urandom_range(15) == 0);
            br_pc_i      = $urandom;
            br_off_i     = 24'($urandom);
            pc_wr_i      = ($urandom_range(19) == 0);
            pc_wr_data_i = $urandom;
            rst          = ($urandom_range(149) == 0);
            cycle();
        end
        rst = 1'b0; br_taken_i = 1'b0; pc_wr_i = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the width of the PC, addresses and instructions.
REQ-002 The block SHALL have parameter DEPTH, default 4, setting the number of prefetch queue entries (power of two, 2..16).
REQ-003 The block SHALL have parameter RESET_PC, default 0, setting the first fetch address after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port imem_req_o, output, 1 bit: fetch request valid this cycle.
REQ-007 The block SHALL have port imem_addr_o, output, XLEN bits: fetch word address (byte address, bits [1:0] = 0).
REQ-008 The block SHALL have port imem_data_i, input, XLEN bits: instruction returned exactly one cycle after a request.
REQ-009 The block SHALL have port br_taken_i, input, 1 bit: taken branch resolved this cycle.
REQ-010 The block SHALL have port br_pc_i, input, XLEN bits: PC of the branch instruction.
REQ-011 The block SHALL have port br_off_i, input, 24 bits: signed word offset of the branch.
REQ-012 The block SHALL have port pc_wr_i, input, 1 bit: register write to the PC (R15) from the memory stage.
REQ-013 The block SHALL have port pc_wr_data_i, input, XLEN bits: value written to the PC.
REQ-014 The block SHALL have port inst_valid_o, output, 1 bit: queue head holds a valid instruction.
REQ-015 The block SHALL have port inst_o, output, XLEN bits: instruction at the queue head.
REQ-016 The block SHALL have port inst_pc_o, output, XLEN bits: PC of inst_o.
REQ-017 The block SHALL have port inst_ready_i, input, 1 bit: the decoder accepts the head this cycle.

Function
REQ-018 The block SHALL keep a fetch PC, a DEPTH-entry FIFO of {instruction, PC} pairs and one in-flight flag.
REQ-019 The block SHALL assert imem_req_o when in RUN, no redirect is active, and (FIFO count + in-flight) < DEPTH; imem_addr_o SHALL equal the fetch PC.
REQ-020 The block SHALL advance the fetch PC by 4 on each issued request, wrapping modulo 2^XLEN.
REQ-021 The block SHALL push imem_data_i together with its request address into the FIFO in the cycle after the request, unless that response is squashed.
REQ-022 A handshake SHALL occur when inst_valid_o and inst_ready_i are both high, popping the head; push and pop in the same cycle SHALL leave the count unchanged.
REQ-023 inst_valid_o SHALL be high exactly when the count is nonzero; the head outputs SHALL hold stable while inst_valid_o=1 and inst_ready_i=0.
REQ-024 The branch target SHALL be br_pc_i + 8 + (sign_extend(br_off_i) << 2), computed in XLEN bits with wrap-around.
REQ-025 A redirect (br_taken_i or pc_wr_i) SHALL flush the FIFO, squash any in-flight response, load the fetch PC with the target, and suppress imem_req_o that cycle.
REQ-026 When pc_wr_i and br_taken_i are both high, pc_wr_i SHALL win; the bits [1:0] of pc_wr_data_i SHALL be cleared.
REQ-027 A redirect coinciding with a handshake SHALL still flush; the popped instruction counts as consumed.
REQ-028 The state machine SHALL be: IDLE (first cycle after reset, no request) -> RUN; RUN -> REDIR on a redirect; REDIR -> RUN after one cycle, issuing the request to the target on that cycle if space allows; a redirect arriving in REDIR SHALL restart REDIR with the new target.
REQ-029 When the FIFO is full, requests SHALL stop with no entry overwritten; when it is empty, a pop SHALL be impossible because inst_valid_o=0.

Reset
REQ-030 With rst high at a clock edge, the block SHALL set the state to IDLE, the fetch PC to RESET_PC, the count to 0 and clear the in-flight flag.
REQ-031 During and after reset, imem_req_o=0, inst_valid_o=0, inst_o=0 and inst_pc_o=0 until the first push; reset mid-operation SHALL discard all queued and in-flight instructions.

Configuration
REQ-032 With macro FETCH_PC_WRITE_EN defined, pc_wr_i/pc_wr_data_i SHALL redirect as specified; without it, those ports SHALL remain present but be ignored, and only br_taken_i SHALL redirect.

Verification
REQ-033 Reset with RESET_PC=0 and inst_ready_i=1 -> the bench SHALL check requests to 0x0, 0x4, 0x8 starting the 2nd cycle after reset, and inst_pc_o = 0x0, 0x4, 0x8 in order.
REQ-034 inst_ready_i=0 with DEPTH=4 -> the bench SHALL check that exactly 4 entries are held (PCs 0x0..0xC), imem_req_o then stays 0, and the head holds stable.
REQ-035 br_taken_i with br_pc_i=0x100 and br_off_i=0xFFFFFE -> the bench SHALL check the target 0x100, the FIFO empties the next cycle, and the next inst_pc_o = 0x100.
REQ-036 pc_wr_i (0x2003) and br_taken_i in the same cycle, macro defined -> the bench SHALL check that fetch resumes at 0x2000; with the macro undefined it SHALL resume at the branch target.
REQ-037 Fetch PC at 0xFFFFFFFC with XLEN=32 -> the bench SHALL check that the next request address is 0x0.
REQ-038 rst asserted while the FIFO holds 3 entries and one request is in flight -> the bench SHALL check inst_valid_o=0 the next cycle, and that the late response is never delivered.
